qk_feeder: RTL

QK_FEEDER -- requirements
Module: qk_feeder

---
 rtl/qk_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/qk_feeder.sv
// qk_feeder: streams key_len key vectors, then q_len query vectors, from memory to the first MAC column.
// Optional FEEDER_BACKPRESSURE_EN: ofifo_full stalls query reads in EXEC (port is always present).
module qk_feeder #(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int col     = 8,
  parameter int key_len = 10,
  parameter int aw      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [aw-1:0]    key_base,
  input  logic [aw-1:0]    q_base,
  input  logic [aw-1:0]    q_len,
  input  logic             ofifo_full,
  output logic             mem_cen,
  output logic [aw-1:0]    mem_addr,
  input  logic [pr*bw-1:0] mem_rdata,
  output logic [pr*bw-1:0] q_out,
  output logic [1:0]       o_inst,
  output logic             busy,
  output logic             done
);

  localparam int KW = $clog2(key_len + 1);
  localparam int CW = ((KW > aw) ? KW : aw) + 1;
  localparam int DW = $clog2(col + 3) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [aw-1:0]    addr_q, addr_d;
  logic [aw-1:0]    q_base_q, q_base_d;
  logic [aw-1:0]    q_len_q, q_len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       inst_q, inst_d;
  logic [pr*bw-1:0] q_out_q, q_out_d;

  logic stall;
  logic issue;
  logic last_key;
  logic last_q;
  logic flushed;

`ifdef FEEDER_BACKPRESSURE_EN
  assign stall = (state_q == EXEC) && ofifo_full;
`else
  logic unused_ofifo_full;
  assign unused_ofifo_full = ofifo_full;
  assign stall = 1'b0;
`endif

  // Gating with reset keeps the memory idle during the reset cycle itself.
  assign issue    = reset && ((state_q == LOAD) || ((state_q == EXEC) && !stall));
  assign last_key = (cnt_q == CW'(key_len - 1));
  assign last_q   = ((cnt_q + CW'(1)) == CW'(q_len_q));
  assign flushed  = (pend_q == 2'b00) && (inst_q == 2'b00);

  assign mem_cen  = !issue;
  assign mem_addr = addr_q;
  assign q_out    = q_out_q;
  assign o_inst   = inst_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    q_base_d = q_base_q;
    q_len_d  = q_len_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    pend_d   = 2'b00;
    inst_d   = pend_q;
    q_out_d  = (pend_q != 2'b00) ? mem_rdata : q_out_q;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          addr_d   = key_base;
          q_base_d = q_base;
          q_len_d  = q_len;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        pend_d = 2'b01;
        addr_d = addr_q + aw'(1);
        cnt_d  = cnt_q + CW'(1);
        if (last_key) begin
          cnt_d  = '0;
          dcnt_d = '0;
          if (q_len_q == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = EXEC;
            addr_d  = q_base_q;
          end
        end
      end
      EXEC: begin
        if (!stall) begin
          pend_d = 2'b10;
          addr_d = addr_q + aw'(1);
          cnt_d  = cnt_q + CW'(1);
          if (last_q) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        // Count only once the final vector has left q_out.
        if (flushed) begin
          if (dcnt_q == DW'(col + 1)) begin
            done    = reset;
            state_d = IDLE;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      q_base_q <= '0;
      q_len_q  <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      pend_q   <= 2'b00;
      inst_q   <= 2'b00;
      q_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      q_base_q <= q_base_d;
      q_len_q  <= q_len_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      pend_q   <= pend_d;
      inst_q   <= inst_d;
      q_out_q  <= q_out_d;
    end
  end

endmodule
